seq_mult_n: RTL and testbench

- Parametrised, iterative shift-add multiplier. It is the multi-cycle successor to the combinational 32-bit array multiplier.
- Generalised in operand width, with a run-time signed/unsigned mode.
- Uses a START/BUSY/DONE handshake so the control unit can stall on MULT/MULTU instead of paying a full-array combinational delay.
- Produces a 2*WIDTH-bit product split into HI and LO.

---
 rtl/seq_mult_n.sv | 135 +++++++++++++
 tb/tb_seq_mult_n.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_n.sv
// Iterative shift-add multiplier with START/BUSY/DONE handshake and run-time signed mode.
// Optional early termination when the remaining multiplier bits are zero: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a_c;
  logic [WIDTH-1:0]   abs_b_c;
  logic [WIDTH-1:0]   mplier_nxt_c;
  logic [PW-1:0]      prod_c;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Most-negative operand negates to itself, which is its correct unsigned magnitude
    abs_a_c      = (SIGNED && A[WIDTH-1]) ? WIDTH'(-A) : A;
    abs_b_c      = (SIGNED && B[WIDTH-1]) ? WIDTH'(-B) : B;
    mplier_nxt_c = mplier_q >> 1;
    prod_c       = sgn_q ? PW'(-acc_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          sgn_d    = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
          mcand_d  = {WIDTH'(0), abs_a_c};
          mplier_d = abs_b_c;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nxt_c;
        cnt_d    = cnt_q - CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        if ((cnt_q == CNT_W'(1)) || (mplier_nxt_c == '0)) begin
          state_d = FINISH;
        end
`else
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
`endif
      end
      FINISH: begin
        {hi_d, lo_d} = prod_c;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// Scoreboard bench for seq_mult_n: stimulus pushes expected {HI,LO,DONE cycle}, a monitor checks on DONE.
module tb_seq_mult_n;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [31:0]  done_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         SIGNED;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         BUSY;
  logic         DONE;

  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;
  exp_t         sb_q[$];

  seq_mult_n #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED), .A(A), .B(B),
    .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edges from acceptance to DONE for this multiplier operand
  function automatic int unsigned latency(input logic [W-1:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [W-1:0] mag;
    int unsigned  msb;
    mag = (s && b[W-1]) ? W'(-b) : b;
    msb = 0;
    for (int i = 0; i < int'(W); i++) if (mag[i]) msb = i;
    return 2 + msb;
`else
    return W + 1;
`endif
  endfunction

  // Called at a negedge: request an op, then scramble inputs to prove they are not re-sampled
  task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [W-1:0] hi, input logic [W-1:0] lo, input bit push);
    exp_t e;
    A = a; B = b; SIGNED = s; START = 1'b1;
    if (push) begin
      e.hi = hi; e.lo = lo; e.done_cyc = cyc + 1 + latency(b, s);
      sb_q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0; A = ~a; B = ~b; SIGNED = ~s;
    check("busy_after_start", 64'(BUSY), 64'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge CLK);
    check("drain_timeout", 64'(sb_q.size()), 64'(0));
    @(negedge CLK);
    check("done_one_cycle", 64'(DONE), 64'(0));
  endtask

  // Monitor: compare every DONE against the oldest expectation
  always @(negedge CLK) begin
    exp_t e;
    if (RST !== 1'b1 && DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: DONE=1 with no pending op (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("hi", 64'(HI), 64'(e.hi));
        check("lo", 64'(LO), 64'(e.lo));
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("busy_at_done", 64'(BUSY), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[11] = '{
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001},
    '{32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{32'hFFFFFFFD, 32'h00000007, 1'b0, 32'h00000006, 32'hFFFFFFEB},
    '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000},
    '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000},
    '{32'h00000000, 32'hFFFFFFFD, 1'b1, 32'h00000000, 32'h00000000},
    '{32'h00000003, 32'h00000010, 1'b0, 32'h00000000, 32'h00000030},
    '{32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000},
    '{32'h00000007, 32'h00000001, 1'b1, 32'h00000000, 32'h00000007},
    '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001},
    '{32'h00000002, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE}
  };

  initial begin
    RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    check("rst_hi", 64'(HI), 64'(0));
    check("rst_lo", 64'(LO), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_done", 64'(DONE), 64'(0));
    RST = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      start_now(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hi, vecs[i].lo, 1'b1);
      drain();
    end

    // START while busy must be ignored; result comes from the first operands (5 * 0x107)
    @(negedge CLK);
    start_now(32'd5, 32'h107, 1'b0, 32'h0, 32'h523, 1'b1);
    A = 32'd9; B = 32'd9; SIGNED = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_ignore_start", 64'(BUSY), 64'(1));
    drain();

    // Back-to-back: a START presented during the DONE cycle is accepted
    @(negedge CLK);
    start_now(32'd6, 32'd7, 1'b0, 32'h0, 32'h2A, 1'b1);
    begin
      int n;
      n = 0;
      while (DONE !== 1'b1 && n < 100) begin
        @(negedge CLK);
        n++;
      end
      check("b2b_first_done_seen", 64'(DONE), 64'(1));
    end
    start_now(32'd3, 32'h10, 1'b0, 32'h0, 32'h30, 1'b1);
    drain();

    // Reset mid-run aborts with outputs cleared and no later DONE
    @(negedge CLK);
    start_now(32'd5, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_hi", 64'(HI), 64'(0));
    check("midrst_lo", 64'(LO), 64'(0));
    check("midrst_busy", 64'(BUSY), 64'(0));
    check("midrst_done", 64'(DONE), 64'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    check("midrst_idle_busy", 64'(BUSY), 64'(0));
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
